// File: rtl/multiply_r.sv
// Iterative shift-add fraction multiplier: returns the upper WIDTH bits of a*b
// plus a sticky OR of the discarded lower half, retiring K multiplier bits per clock.
module multiply_r #(
   parameter int WIDTH = 8,
   parameter int K     = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] prod,
   output logic             sticky
);

   localparam int N  = WIDTH / K;
   localparam int CW = $clog2(N + 1);

   // state  | meaning
   // S_IDLE | waiting for start
   // S_RUN  | N shift-add edges, then one edge to register the result
   // S_FIN  | done pulse; a new start is accepted here as in S_IDLE
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mq_q, mq_d;
   logic [WIDTH:0]   acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] prod_q, prod_d;
   logic             sticky_q, sticky_d;

   logic [WIDTH:0]   acc_v;
   logic [WIDTH-1:0] mq_v;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         mcand_q  <= '0;
         mq_q     <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         prod_q   <= '0;
         sticky_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mq_q     <= mq_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         prod_q   <= prod_d;
         sticky_q <= sticky_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mq_d     = mq_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      prod_d   = prod_q;
      sticky_d = sticky_q;
      acc_v    = acc_q;
      mq_v     = mq_q;

      case (state_q)
         S_IDLE, S_FIN: begin
            if (start) begin
               mcand_d = a;
               mq_d    = b;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (cnt_q == CW'(N)) begin
               prod_d   = acc_q[WIDTH-1:0];
               sticky_d = |mq_q;
               state_d  = S_FIN;
            end else begin
               // acc is shifted right after every add, so its carry bit never overflows
               for (int i = 0; i < K; i++) begin
                  if (mq_v[0]) acc_v = acc_v + {1'b0, mcand_q};
                  {acc_v, mq_v} = {acc_v, mq_v} >> 1;
               end
               acc_d = acc_v;
               mq_d  = mq_v;
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy   = (state_q == S_RUN);
   assign done   = (state_q == S_FIN);
   assign prod   = prod_q;
   assign sticky = sticky_q;

endmodule
